// File: rtl/seg7_scan_driver.sv
// Time-multiplexed scan driver for a 4-digit common-anode seven-segment display.
// The input word is snapshotted once per frame so a frame never mixes two words.
module seg7_scan_driver #(
  parameter int TICKS_PER_DIGIT = 100000,
  parameter int DEAD_TICKS      = 2000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] sevenSeg,
  input  logic        lz_en,
  input  logic        blank,
  output logic [3:0]  an,
  output logic [7:0]  seg,
  output logic        frame_done
);

  localparam int CW = (TICKS_PER_DIGIT > 1) ? $clog2(TICKS_PER_DIGIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TICKS_PER_DIGIT - 1);
  localparam logic [CW-1:0] CNT_DEAD = CW'(DEAD_TICKS);
  localparam logic [7:0]    ZERO_PAT = 8'h81;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic          primed_q, primed_d;
  logic [31:0]   shw_q, shw_d;
  logic [3:0]    an_q, an_d;
  logic [7:0]    seg_q, seg_d;
  logic          frame_done_q, frame_done_d;

  logic          slot_end;
  logic          frame_wrap;
  logic          dark;
  logic [7:0]    digit_byte [4];
  logic [3:0]    digit_zero;
  logic [3:0]    digit_blanked;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_digit
      assign digit_byte[gi] = shw_q[8*gi +: 8];
      assign digit_zero[gi] = (shw_q[8*gi +: 8] == ZERO_PAT);
    end
  endgenerate

  // Blanking cascades from the most significant digit; the lower two always show.
  assign digit_blanked[3] = lz_en && digit_zero[3];
  assign digit_blanked[2] = digit_blanked[3] && digit_zero[2];
  assign digit_blanked[1] = 1'b0;
  assign digit_blanked[0] = 1'b0;

  assign slot_end   = (cnt_q == CNT_LAST);
  assign frame_wrap = slot_end && (idx_q == 2'd3);

  always_comb begin
    cnt_d        = slot_end ? '0 : cnt_q + 1'b1;
    idx_d        = slot_end ? idx_q + 2'd1 : idx_q;
    primed_d     = 1'b1;
    shw_d        = (!primed_q || frame_wrap) ? sevenSeg : shw_q;
    frame_done_d = frame_wrap;
  end

  // The priming edge is kept dark too, so a zero dead time never flashes the reset word.
  always_comb begin
    dark  = blank || !primed_q || (cnt_q < CNT_DEAD) || digit_blanked[idx_q];
    an_d  = 4'hF;
    seg_d = 8'hFF;
    if (!dark) begin
      an_d  = ~(4'b0001 << idx_q);
      seg_d = digit_byte[idx_q];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      idx_q        <= 2'd0;
      primed_q     <= 1'b0;
      shw_q        <= 32'hFFFF_FFFF;
      an_q         <= 4'hF;
      seg_q        <= 8'hFF;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      primed_q     <= primed_d;
      shw_q        <= shw_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Randomized and directed bench for seg7_scan_driver against an arithmetic
// model that derives slot position from the number of edges since reset release.
module tb_seg7_scan_driver;

  localparam int TPD = 8;
  localparam int DT  = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] seven_seg = 32'hF349_6133;
  logic        lz_en = 1'b0;
  logic        blank = 1'b0;
  logic [3:0]  an;
  logic [7:0]  seg;
  logic        frame_done;

  int          tests_run = 0;
  int          tests_failed = 0;
  int          k = 0;
  logic [31:0] shw_m = 32'hFFFF_FFFF;
  int          lit_cnt [4];
  int          fd_cnt = 0;

  seg7_scan_driver #(.TICKS_PER_DIGIT(TPD), .DEAD_TICKS(DT)) dut (
    .clk(clk), .rst_n(rst_n), .sevenSeg(seven_seg), .lz_en(lz_en),
    .blank(blank), .an(an), .seg(seg), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h (k=%0d)", tag, got, exp, k);
    end
  endtask

  function automatic bit digit_hidden(input int d, input logic [31:0] w, input logic lz);
    bit z3, z2;
    z3 = (w[31:24] == 8'h81);
    z2 = (w[23:16] == 8'h81);
    if (!lz) return 1'b0;
    if (d == 3) return z3;
    if (d == 2) return z3 && z2;
    return 1'b0;
  endfunction

  // One clock edge: predict outputs from the pre-edge slot position, then compare.
  task automatic step();
    int cnt, idx;
    bit dark;
    logic [3:0] sel;
    logic [3:0] exp_an;
    logic [7:0] exp_seg;
    logic       exp_fd;
    @(posedge clk);
    cnt  = k % TPD;
    idx  = (k / TPD) % 4;
    dark = blank || (k == 0) || (cnt < DT) || digit_hidden(idx, shw_m, lz_en);
    sel  = 4'b0001 << idx;
    exp_an  = dark ? 4'hF : ~sel;
    exp_seg = dark ? 8'hFF : shw_m[8*idx +: 8];
    exp_fd  = (cnt == TPD - 1) && (idx == 3);
    if (k == 0 || exp_fd) shw_m = seven_seg;
    k++;
    #1;
    check_eq("an", 32'(an), 32'(exp_an));
    check_eq("seg", 32'(seg), 32'(exp_seg));
    check_eq("frame_done", 32'(frame_done), 32'(exp_fd));
    for (int d = 0; d < 4; d++) begin
      sel = 4'b0001 << d;
      if (an == ~sel) lit_cnt[d]++;
    end
    if (frame_done) fd_cnt++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic clear_counts();
    for (int d = 0; d < 4; d++) lit_cnt[d] = 0;
    fd_cnt = 0;
  endtask

  task automatic check_counts(input string name, input int c3, input int c2, input int c1, input int c0);
    check_eq({name, "_lit3"}, 32'(lit_cnt[3]), 32'(c3));
    check_eq({name, "_lit2"}, 32'(lit_cnt[2]), 32'(c2));
    check_eq({name, "_lit1"}, 32'(lit_cnt[1]), 32'(c1));
    check_eq({name, "_lit0"}, 32'(lit_cnt[0]), 32'(c0));
    check_eq({name, "_frames"}, 32'(fd_cnt), 32'd2);
    $display("[TB] %s: lit %0d/%0d/%0d/%0d frames %0d", name,
             lit_cnt[3], lit_cnt[2], lit_cnt[1], lit_cnt[0], fd_cnt);
  endtask

  // Take a new word and let one frame wrap pass so the shadow holds it.
  task automatic load_word(input logic [31:0] w);
    seven_seg = w;
    step();
    while (k % (4 * TPD) != 0) step();
  endtask

  task automatic release_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    k = 0;
    shw_m = 32'hFFFF_FFFF;
  endtask

  function automatic logic [7:0] rand_byte();
    case ($urandom_range(0, 5))
      0, 1:    return 8'h81;
      2:       return 8'h80;
      3:       return 8'h7F;
      default: return 8'($urandom);
    endcase
  endfunction

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_an", 32'(an), 32'h0000_000F);
    check_eq("rst_seg", 32'(seg), 32'h0000_00FF);
    check_eq("rst_frame_done", 32'(frame_done), 32'h0);
    $display("[TB] reset state checked");

    release_reset();
    clear_counts();
    run(64);
    check_counts("scan_1234", 12, 12, 12, 12);

    // Snapshot coherence: change word in the middle of digit 1
    while (k % 32 != 12) step();
    seven_seg = 32'h8181_8181;
    while (k % 32 != 21) step();
    check_eq("snap_d2_seg", 32'(seg), 32'h49);
    while (k % 32 != 29) step();
    check_eq("snap_d3_seg", 32'(seg), 32'hF3);
    step();
    while (k % 32 != 29) step();
    check_eq("snap_new_seg", 32'(seg), 32'h81);
    $display("[TB] snapshot coherence checked");

    // Leading-zero blanking
    lz_en = 1'b1;
    load_word(32'h8181_6133);
    clear_counts();
    run(64);
    check_counts("lz_0034", 0, 0, 12, 12);
    load_word(32'h8180_6133);
    clear_counts();
    run(64);
    check_counts("lz_00p34", 0, 12, 12, 12);
    load_word(32'h7F7F_7F7F);
    clear_counts();
    run(64);
    check_counts("lz_dash", 12, 12, 12, 12);
    lz_en = 1'b0;

    // Blank mid-frame, counters keep running
    load_word(32'hF349_6133);
    while (k % 32 != 13) step();
    blank = 1'b1;
    run(10);
    check_eq("blank_an", 32'(an), 32'h0000_000F);
    blank = 1'b0;
    run(20);
    $display("[TB] blank window checked");

    // Asynchronous reset during idx=2, cnt=5
    while (k % 32 != 21) step();
    check_eq("pre_rst_an", 32'(an), 32'h0000_000B);
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_an", 32'(an), 32'h0000_000F);
    check_eq("async_rst_seg", 32'(seg), 32'h0000_00FF);
    repeat (2) @(posedge clk);
    release_reset();
    run(3);
    check_eq("restart_an", 32'(an), 32'h0000_000E);
    check_eq("restart_seg", 32'(seg), 32'h0000_0033);
    run(29);
    $display("[TB] mid-operation reset checked");

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      step();
      if ($urandom_range(0, 7) == 0)
        seven_seg = {rand_byte(), rand_byte(), rand_byte(), rand_byte()};
      if ($urandom_range(0, 15) == 0) lz_en = ~lz_en;
      if ($urandom_range(0, 19) == 0) blank = ~blank;
    end
    $display("[TB] random phase done, %0d checks so far", tests_run);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Time-multiplexed scan driver for the 4-digit common-anode seven-segment display. Sits directly downstream of the number-to-seven-segment encoder. It takes the encoder's packed 32-bit, four-byte, active-low segment word and drives the board anode and cathode pins one digit at a time. It adds a per-digit dead time against ghosting, frame-coherent snapshotting of the input word, and optional leading-zero blanking.

## Interface
- TICKS_PER_DIGIT, 100000, clock cycles per digit slot (1 kHz digit rate at 100 MHz); must be ≥ 2
- DEAD_TICKS, 2000, cycles at the start of each slot with all anodes off; must be < TICKS_PER_DIGIT
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- sevenSeg  in  32  packed segment word:
  - byte k = bits [8k+7:8k]; byte 3 is the thousands digit, byte 0 is the ones digit
  - each byte is active-low, bits [7:1] = g,f,e,d,c,b,a, bit 0 = decimal point
- lz_en  in  1  leading-zero blanking enable
- blank  in  1  forces the display dark while high
- an  out  4  anode enables, active-low; an[k] selects digit k
- seg  out  8  cathodes, active-low, same bit order as a sevenSeg byte
- frame_done  out  1  one-cycle pulse at the end of each 4-digit frame

## Operation
- Prescaler `cnt` (width $clog2(TICKS_PER_DIGIT)) counts 0..TICKS_PER_DIGIT-1, then wraps to 0.
- Digit index `idx` (2 bits) advances on wrap, in the order 0→1→2→3→0.
- Shadow register `shw` (32 bits) holds the word being displayed. It loads from sevenSeg:
  - on the first rising edge after rst_n deasserts (tracked by a `primed` flag, reset 0);
  - at every frame wrap, i.e. the edge where cnt==TICKS_PER_DIGIT-1 and idx==3.
- Between loads, sevenSeg changes have no effect. A frame never mixes two input words.
- Digit k is blanked when lz_en==1 and either condition holds:
  - k==3 and shw byte 3 == 8'h81 (plain "0", no point);
  - k==2, digit 3 is blanked, and shw byte 2 == 8'h81.
- Digits 1 and 0 are never blanked.
- A byte carrying a point (e.g. 8'h80) is not a zero match. The dash pattern 8'h7F is not a zero match.
- Output select, computed from the current (idx, cnt, shw, blank, lz_en):
  - dark when blank==1, or cnt < DEAD_TICKS, or digit idx is blanked; dark means an=4'b1111 and seg=8'hFF;
  - otherwise an = ~(4'b0001 << idx) and seg = shw byte idx.
- Counters and the shadow keep running while blank is high.
- frame_done = 1 for exactly one cycle after the frame-wrap edge.

## Timing
- Reset (asynchronous assert) values:
  - cnt=0, idx=0, primed=0, shw=32'hFFFF_FFFF
  - an=4'b1111, seg=8'hFF, frame_done=0
- an and seg are registered. They reflect the (idx, cnt) state of the previous cycle, so there is 1-cycle latency from a state change to the pins.
- an and seg always change on the same edge. There is no cycle in which an selects a digit while seg holds another digit's byte.
- Frame period is 4·TICKS_PER_DIGIT cycles. Lit time per digit slot is TICKS_PER_DIGIT−DEAD_TICKS cycles.
- First frame after reset:
  - shw loads on edge 1;
  - the first lit output appears on the edge after the one where cnt reaches DEAD_TICKS;
  - during edge 1 and the dead time, an=4'b1111 and seg=8'hFF.
- blank asserting or deasserting takes effect on an/seg at the next edge. It does not reset the counters.
- When a sevenSeg change coincides with the frame-wrap edge, the new value is captured.
- Reset asserted mid-slot: outputs go dark immediately (asynchronously). After release, scanning restarts at idx 0, cnt 0, and the first-edge load is repeated.

## Test plan
All scenarios use TICKS_PER_DIGIT=8, DEAD_TICKS=2.
- Reset check: hold rst_n=0, sevenSeg=32'hF3_49_61_33 ("1234") → an=1111, seg=FF, frame_done=0. Release reset → an=1110 with seg=33 for exactly 6 cycles, then 1101/61, then 1011/49, then 0111/F3. Each slot is preceded by 2 dark cycles. frame_done pulses once per 32 cycles.
- Snapshot coherence: change sevenSeg to 32'h81_81_81_81 in the middle of idx=1 → digits 2 and 3 of the current frame still show 49 and F3. All digits show 81 from the next frame onward.
- Leading zeros: lz_en=1, sevenSeg=32'h81_81_61_33 ("0034") → an[3] and an[2] are never driven low, and digits 1 and 0 are lit. With sevenSeg=32'h81_80_61_33 ("00.34") → only an[3] is suppressed.
- Zero-with-point dashes: lz_en=1, sevenSeg=32'h7F7F7F7F → all four digits lit, seg=7F each.
- Blank: assert blank for 10 cycles mid-frame → an=1111 and seg=FF on the next edge and throughout. After release, the digit sequence resumes at the position the counters reached (no restart).
- Reset mid-operation: pull rst_n low during idx=2, cnt=5 → an=1111 with no clock edge needed. After release, scanning restarts at an=1110 after 2 dark cycles.
